// File: rtl/kpyd_scanner.sv
// Matrix keypad scanner: column drive, row synchroniser, per-key debounce and a valid/ready event port.
// Optional release events are built when KPYD_RELEASE_EVENTS_EN is defined.
module kpyd_scanner #(
   parameter int unsigned ROWS_P           = 4,
   parameter int unsigned COLS_P           = 4,
   parameter int unsigned SCAN_CYCLES_P    = 1200,
   parameter int unsigned DEBOUNCE_SCANS_P = 4
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [ROWS_P-1:0]                 kpyd_row_i,
   output logic [COLS_P-1:0]                 kpyd_col_o,
   output logic [ROWS_P*COLS_P-1:0]          keys_o,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic [$clog2(ROWS_P*COLS_P)-1:0]  key_code_o,
   output logic                              key_release_o,
   output logic                              overflow_o
);

   localparam int unsigned KEYS_LP   = ROWS_P * COLS_P;
   localparam int unsigned CODE_W_LP = $clog2(KEYS_LP);
   localparam int unsigned COL_W_LP  = $clog2(COLS_P);
   localparam int unsigned DWELL_W_LP = $clog2(SCAN_CYCLES_P);
   localparam int unsigned DB_W_LP   = $clog2(DEBOUNCE_SCANS_P + 1);

   logic [ROWS_P-1:0]     r_row_meta;
   logic [ROWS_P-1:0]     r_row_sync;
   logic [DWELL_W_LP-1:0] r_dwell;
   logic [COL_W_LP-1:0]   r_col_idx;
   logic [COLS_P-1:0]     r_col_drv;
   logic [KEYS_LP-1:0]    r_keys;
   logic [DB_W_LP-1:0]    r_db_cnt [KEYS_LP];
   logic [KEYS_LP-1:0]    r_press_pend;
   logic                  r_valid;
   logic [CODE_W_LP-1:0]  r_code;
   logic                  r_overflow;

   logic                  w_tc;
   logic [DWELL_W_LP-1:0] w_dwell_nxt;
   logic [COL_W_LP-1:0]   w_col_nxt;
   logic [CODE_W_LP-1:0]  w_k;
   logic [KEYS_LP-1:0]    w_keys_nxt;
   logic [DB_W_LP-1:0]    w_db_nxt [KEYS_LP];
   logic [KEYS_LP-1:0]    w_press_set;
   logic [KEYS_LP-1:0]    w_press_keep;
   logic [KEYS_LP-1:0]    w_pend_any;
   logic                  w_sel_found;
   logic [CODE_W_LP-1:0]  w_sel_code;
   logic                  w_load;
   logic [KEYS_LP-1:0]    w_sel_mask;
   logic                  w_ovf;

`ifdef KPYD_RELEASE_EVENTS_EN
   logic [KEYS_LP-1:0]    r_release_pend;
   logic                  r_release;
   logic [KEYS_LP-1:0]    w_rel_set;
   logic [KEYS_LP-1:0]    w_rel_keep;
   logic                  w_sel_rel;
`endif

   // Column dwell timer; sample happens on the terminal count cycle
   assign w_tc        = (r_dwell == DWELL_W_LP'(SCAN_CYCLES_P - 1));
   assign w_dwell_nxt = w_tc ? '0 : r_dwell + DWELL_W_LP'(1);
   assign w_col_nxt   = (r_col_idx == COL_W_LP'(COLS_P - 1)) ? '0 : r_col_idx + COL_W_LP'(1);

   // Debounce the rows of the current column
   always_comb begin
      w_keys_nxt  = r_keys;
      w_db_nxt    = r_db_cnt;
      w_press_set = '0;
`ifdef KPYD_RELEASE_EVENTS_EN
      w_rel_set   = '0;
`endif
      w_k         = '0;
      if (w_tc) begin
         for (int unsigned r = 0; r < ROWS_P; r++) begin
            w_k = CODE_W_LP'(r * COLS_P) + CODE_W_LP'(r_col_idx);
            if ((~r_row_sync[r]) == r_keys[w_k]) begin
               w_db_nxt[w_k] = '0;
            end else if (r_db_cnt[w_k] == DB_W_LP'(DEBOUNCE_SCANS_P - 1)) begin
               w_db_nxt[w_k]   = '0;
               w_keys_nxt[w_k] = ~r_keys[w_k];
               if (!r_keys[w_k]) w_press_set[w_k] = 1'b1;
`ifdef KPYD_RELEASE_EVENTS_EN
               else              w_rel_set[w_k]   = 1'b1;
`endif
            end else begin
               w_db_nxt[w_k] = r_db_cnt[w_k] + DB_W_LP'(1);
            end
         end
      end
   end

`ifdef KPYD_RELEASE_EVENTS_EN
   assign w_pend_any = r_press_pend | r_release_pend;
`else
   assign w_pend_any = r_press_pend;
`endif

   // Lowest pending index wins; a key's press goes before its release
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_code  = '0;
`ifdef KPYD_RELEASE_EVENTS_EN
      w_sel_rel   = 1'b0;
`endif
      for (int i = int'(KEYS_LP) - 1; i >= 0; i--) begin
         if (w_pend_any[i]) begin
            w_sel_found = 1'b1;
            w_sel_code  = CODE_W_LP'(i);
`ifdef KPYD_RELEASE_EVENTS_EN
            w_sel_rel   = ~r_press_pend[i];
`endif
         end
      end
   end

   assign w_load     = (!r_valid || ready_i) && w_sel_found;
   assign w_sel_mask = w_load ? (KEYS_LP'(1) << w_sel_code) : '0;

`ifdef KPYD_RELEASE_EVENTS_EN
   assign w_press_keep = r_press_pend   & ~(w_sel_rel ? '0 : w_sel_mask);
   assign w_rel_keep   = r_release_pend & ~(w_sel_rel ? w_sel_mask : '0);
   assign w_ovf        = (|(w_press_set & w_press_keep)) | (|(w_rel_set & w_rel_keep));
`else
   assign w_press_keep = r_press_pend & ~w_sel_mask;
   assign w_ovf        = |(w_press_set & w_press_keep);
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_row_meta   <= '1;
         r_row_sync   <= '1;
         r_dwell      <= '0;
         r_col_idx    <= '0;
         r_col_drv    <= ~COLS_P'(1);
         r_keys       <= '0;
         for (int unsigned i = 0; i < KEYS_LP; i++) r_db_cnt[i] <= '0;
         r_press_pend <= '0;
         r_valid      <= 1'b0;
         r_code       <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_row_meta   <= kpyd_row_i;
         r_row_sync   <= r_row_meta;
         r_dwell      <= w_dwell_nxt;
         if (w_tc) begin
            r_col_idx <= w_col_nxt;
            r_col_drv <= ~(COLS_P'(1) << w_col_nxt);
         end
         r_keys       <= w_keys_nxt;
         r_db_cnt     <= w_db_nxt;
         r_press_pend <= w_press_keep | w_press_set;
         r_overflow   <= r_overflow | w_ovf;
         if (!r_valid || ready_i) begin
            r_valid <= w_sel_found;
            if (w_sel_found) r_code <= w_sel_code;
         end
      end
   end

`ifdef KPYD_RELEASE_EVENTS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_release_pend <= '0;
         r_release      <= 1'b0;
      end else begin
         r_release_pend <= w_rel_keep | w_rel_set;
         if (w_load) r_release <= w_sel_rel;
      end
   end
   assign key_release_o = r_release;
`else
   assign key_release_o = 1'b0;
`endif

   assign kpyd_col_o = r_col_drv;
   assign keys_o     = r_keys;
   assign valid_o    = r_valid;
   assign key_code_o = r_code;
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_kpyd_scanner.sv
// Bench for kpyd_scanner (4x4, 4-clock dwell, 2-sample debounce) with a behavioural keypad model.
module tb_kpyd_scanner;

`ifdef KPYD_RELEASE_EVENTS_EN
   localparam logic REL_EN = 1'b1;
`else
   localparam logic REL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_i;
   logic        ready_i;
   logic [3:0]  kpyd_row_i;
   logic [3:0]  kpyd_col_o;
   logic [15:0] keys_o;
   logic        valid_o;
   logic [3:0]  key_code_o;
   logic        key_release_o;
   logic        overflow_o;
   logic [15:0] press;

   int n_vec = 0;
   int n_err = 0;

   kpyd_scanner #(
      .ROWS_P(4), .COLS_P(4), .SCAN_CYCLES_P(4), .DEBOUNCE_SCANS_P(2)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .kpyd_row_i(kpyd_row_i), .kpyd_col_o(kpyd_col_o),
      .keys_o(keys_o), .valid_o(valid_o), .ready_i(ready_i), .key_code_o(key_code_o),
      .key_release_o(key_release_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      kpyd_row_i = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[r*4+c] && !kpyd_col_o[c]) kpyd_row_i[r] = 1'b0;
   end

   typedef struct {
      string       name;
      logic        rst;
      logic        rdy;
      logic [15:0] press;
      int          ncyc;
      logic [3:0]  col;
      logic [15:0] keys;
      logic        valid;
      logic        chk;
      logic [3:0]  code;
      logic        rel;
      logic        ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string name, input logic rst, input logic rdy, input logic [15:0] pr,
                      input int ncyc, input logic [3:0] col, input logic [15:0] keys,
                      input logic valid, input logic chk, input logic [3:0] code,
                      input logic rel, input logic ovf);
      vec_t v;
      v.name = name; v.rst = rst; v.rdy = rdy; v.press = pr; v.ncyc = ncyc;
      v.col = col; v.keys = keys; v.valid = valid; v.chk = chk; v.code = code;
      v.rel = rel; v.ovf = ovf;
      tbl.push_back(v);
   endtask

   task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   int lat;

   initial begin
      reset_i = 1'b1;
      ready_i = 1'b1;
      press   = '0;

      // name, rst, rdy, press, ncyc | col, keys, valid, chk_code, code, rel, ovf
      add("t1_reset",   1, 1, 16'h0000,  2, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t1_col1",    0, 1, 16'h0000,  4, 4'b1101, 16'h0000, 0, 1, 0, 0, 0);
      add("t1_wrap",    0, 1, 16'h0000, 12, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t2_reset",   1, 0, 16'h0000,  1, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t2_sample1", 0, 0, 16'h0040, 12, 4'b0111, 16'h0000, 0, 1, 0, 0, 0);
      add("t2_toggle",  0, 0, 16'h0040, 16, 4'b0111, 16'h0040, 0, 1, 0, 0, 0);
      add("t2_valid",   0, 0, 16'h0040,  1, 4'b0111, 16'h0040, 1, 1, 6, 0, 0);
      add("t2_hold",    0, 0, 16'h0040,  6, 4'b1110, 16'h0040, 1, 1, 6, 0, 0);
      add("t2_xfer",    0, 1, 16'h0040,  1, 4'b1101, 16'h0040, 0, 0, 0, 0, 0);
      add("t6_release", 0, 1, 16'h0000, 25, 4'b0111, 16'h0000, REL_EN, REL_EN, 6, REL_EN, 0);
      add("t6_rel_xfer",0, 1, 16'h0000,  1, 4'b0111, 16'h0000, 0, 0, 0, 0, 0);
      add("t3_reset",   1, 1, 16'h0000,  1, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t3_one_smp", 0, 1, 16'h0040, 12, 4'b0111, 16'h0000, 0, 0, 0, 0, 0);
      add("t3_released",0, 1, 16'h0000, 20, 4'b1110, 16'h0000, 0, 0, 0, 0, 0);
      add("t3_cnt_clr", 0, 1, 16'h0040, 16, 4'b1110, 16'h0000, 0, 0, 0, 0, 0);
      add("t3_no_event",0, 1, 16'h0000,  1, 4'b1110, 16'h0000, 0, 0, 0, 0, 0);
      add("t5_reset",   1, 0, 16'h0000,  1, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t5_key1",    0, 0, 16'h0002, 25, 4'b1011, 16'h0002, 1, 1, 1, 0, 0);
      add("t5_key0_pnd",0, 0, 16'h0003, 28, 4'b1101, 16'h0003, 1, 1, 1, 0, 0);
      add("t5_key0_rel",0, 0, 16'h0002, 32, 4'b1101, 16'h0002, 1, 1, 1, 0, 0);
      add("t5_overflow",0, 0, 16'h0003, 32, 4'b1101, 16'h0003, 1, 1, 1, 0, 1);
      add("t5_deliver0",0, 1, 16'h0003,  1, 4'b1101, 16'h0003, 1, 1, 0, 0, 1);
      add("t5_after0",  0, 1, 16'h0003,  1, 4'b1101, 16'h0003, REL_EN, REL_EN, 0, REL_EN, 1);
      add("t5_drained", 0, 1, 16'h0003,  1, 4'b1011, 16'h0003, 0, 0, 0, 0, 1);
      add("t7_key2",    0, 0, 16'h0007, 21, 4'b0111, 16'h0007, 1, 1, 2, 0, 1);
      add("t7_reset",   1, 0, 16'h0000,  1, 4'b1110, 16'h0000, 0, 1, 0, 0, 0);
      add("t7_run",     0, 1, 16'h0000,  4, 4'b1101, 16'h0000, 0, 1, 0, 0, 0);

      foreach (tbl[i]) begin
         reset_i = tbl[i].rst;
         ready_i = tbl[i].rdy;
         press   = tbl[i].press;
         repeat (tbl[i].ncyc) @(posedge clk);
         #1;
         n_vec++;
         if (kpyd_col_o !== tbl[i].col || keys_o !== tbl[i].keys || valid_o !== tbl[i].valid ||
             overflow_o !== tbl[i].ovf ||
             (tbl[i].chk && (key_code_o !== tbl[i].code || key_release_o !== tbl[i].rel))) begin
            n_err++;
            $display("FAIL %s: col=%b keys=%h valid=%b code=%0d rel=%b ovf=%b, want col=%b keys=%h valid=%b code=%0d rel=%b ovf=%b",
                     tbl[i].name, kpyd_col_o, keys_o, valid_o, key_code_o, key_release_o, overflow_o,
                     tbl[i].col, tbl[i].keys, tbl[i].valid, tbl[i].code, tbl[i].rel, tbl[i].ovf);
         end
      end

      // Two keys in one column toggle together and drain on back-to-back cycles
      reset_i = 1'b1;
      ready_i = 1'b1;
      press   = '0;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      press   = 16'h2002;
      lat     = 0;
      while (!valid_o && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk_val("t4_latency", 32'(lat), 32'd25);
      chk_val("t4_keys", 32'(keys_o), 32'h2002);
      chk_val("t4_first_code", {27'd0, valid_o, key_code_o}, {27'd0, 1'b1, 4'd1});
      @(posedge clk);
      #1;
      chk_val("t4_second_code", {27'd0, valid_o, key_code_o}, {27'd0, 1'b1, 4'd13});
      chk_val("t4_second_rel", 32'(key_release_o), 32'd0);
      @(posedge clk);
      #1;
      chk_val("t4_drained", 32'(valid_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
